// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: VGA timing generator with a BPP-bit framebuffer and palette.
// A write port stores palette indices into the framebuffer. Scan-out runs a
// 2-stage pipeline: RAM read, then registered palette lookup.
// Optional feature macro: VGA_FB_PALETTE_EN.
//   Defined:   the palette is a writable register file.
//   Undefined: the palette is a fixed table and the pal_* inputs are ignored.
module vga_fb_ctrl #(
    parameter int HD             = 1280,
    parameter int VD             = 1024,
    parameter int HF             = 48,
    parameter int HR             = 112,
    parameter int HB             = 248,
    parameter int VF             = 1,
    parameter int VR             = 3,
    parameter int VB             = 38,
    parameter int BPP            = 2,
    parameter int WR_VBLANK_ONLY = 0,
    localparam int XW            = $clog2(HD + HF + HR + HB),
    localparam int YW            = $clog2(VD + VF + VR + VB)
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [XW-1:0]   wr_x_i,
    input  logic [YW-1:0]   wr_y_i,
    input  logic [BPP-1:0]  wr_color_i,
    output logic            wr_err_o,
    input  logic            pal_we_i,
    input  logic [BPP-1:0]  pal_idx_i,
    input  logic [11:0]     pal_rgb_i,
    output logic            VGA_HS_o,
    output logic            VGA_VS_o,
    output logic [11:0]     RGB_o,
    output logic            frame_start_o
);

    localparam int HT   = HD + HF + HR + HB;
    localparam int VT   = VD + VF + VR + VB;
    localparam int NPIX = HD * VD;
    localparam int AW   = $clog2(NPIX);
    localparam int NPAL = 1 << BPP;

    localparam logic [XW-1:0] H_LAST = XW'(HT - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(HD);
    localparam logic [XW-1:0] H_SS   = XW'(HD + HF);
    localparam logic [XW-1:0] H_SE   = XW'(HD + HF + HR);
    localparam logic [YW-1:0] V_LAST = YW'(VT - 1);
    localparam logic [YW-1:0] V_VIS  = YW'(VD);
    localparam logic [YW-1:0] V_SS   = YW'(VD + VF);
    localparam logic [YW-1:0] V_SE   = YW'(VD + VF + VR);

    // Row-major framebuffer address, shared by the write and scan-out sides.
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(int'(y) * HD + int'(x));
    endfunction

    // Power-up palette: black, white, red, green, then black for the rest.
    function automatic logic [11:0] pal_default(input logic [BPP-1:0] idx);
        logic [3:0] i4;
        i4 = 4'(idx);
        case (i4)
            4'd0:    return 12'h000;
            4'd1:    return 12'hFFF;
            4'd2:    return 12'hF00;
            4'd3:    return 12'h0F0;
            default: return 12'h000;
        endcase
    endfunction

    logic [XW-1:0]  hcount_q, hcount_d;
    logic [YW-1:0]  vcount_q, vcount_d;
    logic           wr_ready_q, wr_ready_d;
    logic           wr_err_q, wr_err_d;
    logic [BPP-1:0] mem_q [NPIX];

    // Stage 1 holds the RAM read; stage 2 holds the palette lookup.
    logic [BPP-1:0] pix_q;
    logic           vis_p1_q, hs_p1_q, vs_p1_q, fs_p1_q;
    logic           hs_p2_q, vs_p2_q, fs_p2_q;
    logic [11:0]    rgb_q, rgb_d;

    logic           vis_s, hs_s, vs_s, fs_s;
    logic [AW-1:0]  rd_addr_s, wr_addr_s;
    logic           wr_acc_s, wr_in_s, wr_en_s;
    logic [11:0]    pal_rgb_s;

    // Counter next state, raw timing flags, and write acceptance.
    always_comb begin
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        rd_addr_s  = '0;
        wr_addr_s  = '0;
        wr_ready_d = 1'b1;
        wr_err_d   = 1'b0;
        rgb_d      = 12'h000;

        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            if (vcount_q == V_LAST) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + YW'(1);
            end
        end else begin
            hcount_d = hcount_q + XW'(1);
            vcount_d = vcount_q;
        end

        vis_s = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        hs_s  = !((hcount_q >= H_SS) && (hcount_q < H_SE));
        vs_s  = !((vcount_q >= V_SS) && (vcount_q < V_SE));
        fs_s  = (hcount_q == '0) && (vcount_q == '0);

        if (vis_s) begin
            rd_addr_s = pix_addr(hcount_q, vcount_q);
        end else begin
            rd_addr_s = '0;
        end

        wr_acc_s = wr_valid_i && wr_ready_q;
        wr_in_s  = (wr_x_i < H_VIS) && (wr_y_i < V_VIS);
        wr_en_s  = wr_acc_s && wr_in_s;
        wr_err_d = wr_acc_s && !wr_in_s;

        if (wr_in_s) begin
            wr_addr_s = pix_addr(wr_x_i, wr_y_i);
        end else begin
            wr_addr_s = '0;
        end

        // Ready is registered, so it is computed from the line about to start.
        if (WR_VBLANK_ONLY != 0) begin
            wr_ready_d = (vcount_d >= V_VIS);
        end else begin
            wr_ready_d = 1'b1;
        end

        if (vis_p1_q) begin
            rgb_d = pal_rgb_s;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Framebuffer storage; reset leaves the image intact.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_color_i;
        end
    end

`ifdef VGA_FB_PALETTE_EN
    logic [11:0] pal_q [NPAL];

    // Writable palette, loaded with the default table on reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= pal_default(BPP'(i));
            end
        end else if (pal_we_i) begin
            pal_q[pal_idx_i] <= pal_rgb_i;
        end
    end

    // Palette lookup of the pixel read in stage 1.
    always_comb begin
        pal_rgb_s = pal_q[pix_q];
    end
`else
    logic unused_pal_s;

    // Fixed palette lookup; the palette write port has no effect.
    always_comb begin
        pal_rgb_s    = pal_default(pix_q);
        unused_pal_s = ^{pal_we_i, pal_idx_i, pal_rgb_i};
    end
`endif

    // Timing counters, write handshake, and the two scan-out stages.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            pix_q      <= '0;
            vis_p1_q   <= 1'b0;
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            fs_p1_q    <= 1'b0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            fs_p2_q    <= 1'b0;
            rgb_q      <= 12'h000;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            pix_q      <= mem_q[rd_addr_s];
            vis_p1_q   <= vis_s;
            hs_p1_q    <= hs_s;
            vs_p1_q    <= vs_s;
            fs_p1_q    <= fs_s;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
            fs_p2_q    <= fs_p1_q;
            rgb_q      <= rgb_d;
        end
    end

    assign wr_ready_o    = wr_ready_q;
    assign wr_err_o      = wr_err_q;
    assign VGA_HS_o      = hs_p2_q;
    assign VGA_VS_o      = vs_p2_q;
    assign RGB_o         = rgb_q;
    assign frame_start_o = fs_p2_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Testbench for vga_fb_ctrl with a small 8x4 screen (14x7 total).
// A reference model runs beside the DUT and pushes the expected scan-out for
// every pixel into a queue; the queue is popped when that pixel reaches the
// outputs, two clocks later. Directed steps cover writes, range errors, the
// vblank-only write mode, palette writes, and reset mid-frame.
module tb_vga_fb_ctrl;

    localparam int HD = 8, VD = 4, HF = 2, HR = 2, HB = 2, VF = 1, VR = 1, VB = 1, BPP = 2;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        wr_valid = 1'b0, wr_valid_vb = 1'b0;
    logic [3:0]  wr_x = 4'd0;
    logic [2:0]  wr_y = 3'd0;
    logic [1:0]  wr_color = 2'd0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = 2'd0;
    logic [11:0] pal_rgb = 12'h000;

    logic        wr_ready, wr_err, hs, vs, fs;
    logic [11:0] rgb;
    logic        wr_ready_vb, wr_err_vb, hs_vb, vs_vb, fs_vb;
    logic [11:0] rgb_vb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_fb_ctrl #(.HD(HD), .VD(VD), .HF(HF), .HR(HR), .HB(HB), .VF(VF), .VR(VR), .VB(VB),
                  .BPP(BPP), .WR_VBLANK_ONLY(0)) dut (
        .clk_i(clk), .arst_i(arst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_color_i(wr_color), .wr_err_o(wr_err),
        .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
        .VGA_HS_o(hs), .VGA_VS_o(vs), .RGB_o(rgb), .frame_start_o(fs));

    vga_fb_ctrl #(.HD(HD), .VD(VD), .HF(HF), .HR(HR), .HB(HB), .VF(VF), .VR(VR), .VB(VB),
                  .BPP(BPP), .WR_VBLANK_ONLY(1)) dut_vb (
        .clk_i(clk), .arst_i(arst), .wr_valid_i(wr_valid_vb), .wr_ready_o(wr_ready_vb),
        .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_color_i(wr_color), .wr_err_o(wr_err_vb),
        .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
        .VGA_HS_o(hs_vb), .VGA_VS_o(vs_vb), .RGB_o(rgb_vb), .frame_start_o(fs_vb));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pal_rst(input int i);
        case (i)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'hF00;
            3:       return 12'h0F0;
            default: return 12'h000;
        endcase
    endfunction

    // Reference model state.
    int          mh, mv;
    logic        rdy_m, err_m;
    logic [1:0]  fb_m [HD*VD];
    bit          fb_ok_m [HD*VD];
    logic [11:0] pal_m [4];

    // Model: counters, write acceptance, palette updates.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            mh    <= 0;
            mv    <= 0;
            rdy_m <= 1'b0;
            err_m <= 1'b0;
            for (int i = 0; i < 4; i++) pal_m[i] <= pal_rst(i);
        end else begin
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
            err_m <= 1'b0;
            if (wr_valid && rdy_m) begin
                if (int'(wr_x) < HD && int'(wr_y) < VD) begin
                    fb_m[int'(wr_y) * HD + int'(wr_x)]    <= wr_color;
                    fb_ok_m[int'(wr_y) * HD + int'(wr_x)] <= 1'b1;
                end else begin
                    err_m <= 1'b1;
                end
            end
            rdy_m <= 1'b1;
`ifdef VGA_FB_PALETTE_EN
            if (pal_we) pal_m[pal_idx] <= pal_rgb;
`endif
        end
    end

    typedef struct {
        int          h, v;
        logic        hs, vs, fs, vis, known;
        logic [1:0]  idx;
        logic [11:0] rgb;
    } ent_t;

    ent_t q[$];
    int   out_h = -1, out_v = -1;

    // Scoreboard: pop and compare, resolve the palette, push the current pixel.
    always @(negedge clk) begin
        ent_t e;
        int   a;
        if (arst) begin
            q.delete();
            out_h = -1;
            out_v = -1;
        end else begin
            if (q.size() == 2) begin
                e = q.pop_front();
                check("hsync", 32'(hs), 32'(e.hs));
                check("vsync", 32'(vs), 32'(e.vs));
                check("frame_start", 32'(fs), 32'(e.fs));
                if (e.known) check("rgb", 32'(rgb), 32'(e.rgb));
                out_h = e.h;
                out_v = e.v;
            end
            if (q.size() == 1) begin
                e = q.pop_front();
                e.rgb = e.vis ? pal_m[e.idx] : 12'h000;
                q.push_front(e);
            end
            e.h   = mh;
            e.v   = mv;
            e.hs  = !(mh >= HD + HF && mh < HD + HF + HR);
            e.vs  = !(mv >= VD + VF && mv < VD + VF + VR);
            e.fs  = (mh == 0 && mv == 0);
            e.vis = (mh < HD && mv < VD);
            a     = e.vis ? mv * HD + mh : 0;
            e.known = !e.vis || fb_ok_m[a];
            e.idx = e.vis ? fb_m[a] : 2'd0;
            e.rgb = 12'h000;
            q.push_back(e);
            check("wr_ready", 32'(wr_ready), 32'(rdy_m));
            check("wr_err", 32'(wr_err), 32'(err_m));
            check("wr_ready_vblank", 32'(wr_ready_vb), 32'(mv >= VD));
        end
    end

    task automatic px_write(input int x, input int y, input int c);
        @(negedge clk);
        wr_x     = 4'(x);
        wr_y     = 3'(y);
        wr_color = 2'(c);
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_out(input int h, input int v, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            #1;
            if (out_h == h && out_v == v) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_hs", 32'(hs), 32'd1);
        check("rst_vs", 32'(vs), 32'd1);
        check("rst_rgb", 32'(rgb), 32'h000);
        check("rst_fs", 32'(fs), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_err", 32'(wr_err), 32'd0);
    endtask

    initial begin
        int cnt_fs, cnt_hs, cnt_vs, cnt_err, acc_h, acc_v;
        logic [11:0] exp_pal1;

        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #2 arst = 1'b0;

        // Clear the framebuffer, then paint two pixels.
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                px_write(x, y, 0);
        px_write(3, 2, 2);
        px_write(5, 1, 1);

        // Free-run one full frame counting sync and frame pulses.
        cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            #1;
            if (fs) cnt_fs++;
            if (!hs) cnt_hs++;
            if (!vs) cnt_vs++;
        end
        check("frame_start_per_frame", 32'(cnt_fs), 32'd1);
        check("hs_low_per_frame", 32'(cnt_hs), 32'(2 * VT));
        check("vs_low_per_frame", 32'(cnt_vs), 32'(HT));

        wait_out(3, 2, "reach_pixel_3_2");
        check("pixel_3_2", 32'(rgb), 32'hF00);

        // Out-of-range write: exactly one error pulse.
        px_write(8, 0, 3);
        cnt_err = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (wr_err) cnt_err++;
            @(negedge clk);
        end
        check("err_pulse_count", 32'(cnt_err), 32'd1);

        // Palette entry 1 rewrite.
        @(negedge clk);
        pal_idx = 2'd1;
        pal_rgb = 12'h0AB;
        pal_we  = 1'b1;
        @(negedge clk);
        pal_we  = 1'b0;
`ifdef VGA_FB_PALETTE_EN
        exp_pal1 = 12'h0AB;
`else
        exp_pal1 = 12'hFFF;
`endif
        repeat (HT * VT) @(negedge clk);
        wait_out(5, 1, "reach_pixel_5_1");
        check("pixel_5_1_palette", 32'(rgb), 32'(exp_pal1));

        // Vblank-only instance: hold a request from line 0.
        acc_h = -1; acc_v = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (mh == 0 && mv == 0) break;
        end
        wr_x = 4'd0; wr_y = 3'd0; wr_color = 2'd1;
        wr_valid_vb = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (wr_ready_vb) begin
                acc_h = mh;
                acc_v = mv;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        wr_valid_vb = 1'b0;
        check("vblank_first_accept_h", 32'(acc_h), 32'd0);
        check("vblank_first_accept_v", 32'(acc_v), 32'd4);

        // Reset in the middle of the frame at (5,1).
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (mh == 5 && mv == 1) break;
        end
        check("reach_5_1_for_reset", 32'(mh * 16 + mv), 32'(5 * 16 + 1));
        arst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_reset_outputs();
        end
        @(posedge clk);
        #2 arst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("frame_start_after_reset", 32'(fs), 32'd1);
        wait_out(3, 2, "reach_pixel_3_2_after_reset");
        check("pixel_3_2_preserved", 32'(rgb), 32'hF00);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
